// File: rtl/pc_sequencer.sv
// Pipeline control sequencer: Moore FSM that drives PC start/stall, IF/ID flush
// and next-PC select, and counts stall cycles.
module pc_sequencer #(
    parameter int FLUSH_CYC = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             go_i,
    input  logic             halt_i,
    input  logic             ld_hazard_i,
    input  logic             branch_taken_i,
    input  logic             imem_ready_i,
    input  logic             dmem_busy_i,
    output logic             start_o,
    output logic             stall_o,
    output logic             flush_o,
    output logic             pc_sel_o,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RUN      = 3'd1,
        HAZ      = 3'd2,
        MEM_WAIT = 3'd3,
        FLUSH    = 3'd4,
        HALT     = 3'd5
    } state_t;

    localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYC - 1);

    state_t           state_q, state_d;
    logic [2:0]       fcnt_q, fcnt_d;
    logic             halt_pend_q, halt_pend_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             start_q, start_d;
    logic             stall_q, stall_d;
    logic             flush_q, flush_d;
    logic             pc_sel_q, pc_sel_d;
    logic             mem_wait;

    assign mem_wait = !imem_ready_i || dmem_busy_i;

    always_comb begin
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        halt_pend_d = halt_pend_q;
        case (state_q)
            IDLE: if (go_i) state_d = RUN;
            RUN: begin
                if (halt_i || halt_pend_q) begin
                    state_d     = HALT;
                    halt_pend_d = 1'b0;
                end else if (mem_wait) begin
                    state_d = MEM_WAIT;
                end else if (branch_taken_i) begin
                    state_d = FLUSH;
                    fcnt_d  = 3'd0;
                end else if (ld_hazard_i) begin
                    state_d = HAZ;
                end
            end
            HAZ: begin
                if (halt_i) halt_pend_d = 1'b1;
                state_d = mem_wait ? MEM_WAIT : RUN;
            end
            MEM_WAIT: begin
                if (halt_i) halt_pend_d = 1'b1;
                if (!mem_wait) state_d = RUN;
            end
            FLUSH: begin
                if (halt_i) halt_pend_d = 1'b1;
                // memory status is deliberately not looked at here; RUN picks it up
                if (fcnt_q >= FLUSH_LAST) begin
                    state_d = RUN;
                    fcnt_d  = 3'd0;
                end else begin
                    fcnt_d = fcnt_q + 3'd1;
                end
            end
            HALT: begin
                if (go_i) begin
                    state_d     = RUN;
                    halt_pend_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are flopped from the next-state decode so they line up with state_q.
    always_comb begin
        start_d  = (state_d == RUN) || (state_d == HAZ) || (state_d == MEM_WAIT) || (state_d == FLUSH);
        stall_d  = (state_d == HAZ) || (state_d == MEM_WAIT);
        flush_d  = (state_d == FLUSH);
        pc_sel_d = (state_d == FLUSH) && (fcnt_d == 3'd0);
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (((state_q == IDLE) || (state_q == HALT)) && go_i)
            stall_cnt_d = '0;
        else if (stall_q && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            fcnt_q      <= 3'd0;
            halt_pend_q <= 1'b0;
            stall_cnt_q <= '0;
            start_q     <= 1'b0;
            stall_q     <= 1'b0;
            flush_q     <= 1'b0;
            pc_sel_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            halt_pend_q <= halt_pend_d;
            stall_cnt_q <= stall_cnt_d;
            start_q     <= start_d;
            stall_q     <= stall_d;
            flush_q     <= flush_d;
            pc_sel_q    <= pc_sel_d;
        end
    end

    assign start_o     = start_q;
    assign stall_o     = stall_q;
    assign flush_o     = flush_q;
    assign pc_sel_o    = pc_sel_q;
    assign state_o     = state_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter FLUSH_CYC, default 1, range 1..7: number of cycles flush_o is held after a taken branch.
REQ-002 Parameter CNT_W, default 16: width of the stall performance counter.
REQ-003 clk_i  input  1  Single clock; all state changes on its rising edge.
REQ-004 rst_i  input  1  Reset; asynchronous, active-high.
REQ-005 go_i  input  1  Run command; sampled in IDLE and HALT only.
REQ-006 halt_i  input  1  Halt request.
REQ-007 ld_hazard_i  input  1  Load-use hazard from decode.
REQ-008 branch_taken_i  input  1  Taken branch or jump resolved in decode.
REQ-009 imem_ready_i  input  1  Instruction memory ready; 0 = fetch miss.
REQ-010 dmem_busy_i  input  1  Data memory busy.
REQ-011 start_o  output  1  Drives PC start_i.
REQ-012 stall_o  output  1  Drives PC stall_i and the IF/ID write-hold.
REQ-013 flush_o  output  1  Clears the IF/ID register.
REQ-014 pc_sel_o  output  1  Next-PC mux select: 0 = PC+4, 1 = branch target.
REQ-015 state_o  output  3  Current state encoding.
REQ-016 stall_cnt_o  output  CNT_W  Count of cycles with stall_o=1.

Function
REQ-017 States SHALL be IDLE=0, RUN=1, HAZ=2, MEM_WAIT=3, FLUSH=4, HALT=5; codes 6-7 SHALL go to IDLE on the next edge.
REQ-018 All outputs SHALL be registered and decoded from state only (Moore). An input sampled at edge N affects the outputs after edge N.
REQ-019 start_o=1 in RUN, HAZ, MEM_WAIT and FLUSH; 0 in IDLE and HALT.
REQ-020 stall_o=1 in HAZ and MEM_WAIT; 0 otherwise.
REQ-021 flush_o=1 in FLUSH only.
REQ-022 pc_sel_o=1 only in the first FLUSH cycle.
REQ-023 IDLE: go_i=1 -> RUN; otherwise stay in IDLE.
REQ-024 RUN transition priority, highest first:
  - halt_i -> HALT
  - (!imem_ready_i | dmem_busy_i) -> MEM_WAIT
  - branch_taken_i -> FLUSH
  - ld_hazard_i -> HAZ
  - otherwise stay in RUN
REQ-025 HAZ SHALL last exactly 1 cycle. Exit: MEM_WAIT if memory is not ready, else RUN. A branch_taken_i sampled in HAZ SHALL be ignored.
REQ-026 MEM_WAIT SHALL hold until imem_ready_i=1 and dmem_busy_i=0, then go to RUN. There is no timeout.
REQ-027 FLUSH SHALL last exactly FLUSH_CYC cycles, counted by an internal 3-bit counter cleared on entry, then go to RUN. Memory-not-ready during FLUSH SHALL be deferred to the RUN evaluation.
REQ-028 halt_i=1 sampled in HAZ, MEM_WAIT or FLUSH SHALL set a halt_pend flag. On the next cycle in RUN, halt_pend SHALL take the halt_i priority slot, and it SHALL clear on HALT entry.
REQ-029 HALT: go_i=1 -> RUN and clear halt_pend; otherwise stay in HALT.
REQ-030 stall_cnt_o SHALL increment on each edge where stall_o=1 and saturate at all-ones. It SHALL clear on go_i=1 sampled in IDLE or HALT.
REQ-031 go_i, halt_i and the hazard inputs asserted in the same RUN cycle SHALL resolve strictly per REQ-024; go_i is ignored in RUN.

Reset
REQ-032 rst_i=1 SHALL immediately force: state=IDLE, start_o=0, stall_o=0, flush_o=0, pc_sel_o=0, stall_cnt_o=0, halt_pend=0, flush counter=0.
REQ-033 Reset asserted mid-FLUSH or mid-MEM_WAIT SHALL abort the operation with no pending effect after release.
REQ-034 After rst_i deasserts, the block SHALL stay in IDLE until go_i.

Verification
REQ-035 Reset release, then go_i pulse -> after 1 edge state_o=1, start_o=1, stall_o=0; with no hazards start_o stays 1 for 10 cycles.
REQ-036 In RUN, ld_hazard_i=1 for 1 cycle -> stall_o=1 for exactly 1 cycle, then state_o=1; stall_cnt_o goes 0->1.
REQ-037 FLUSH_CYC=2, branch_taken_i=1 -> flush_o=1 for 2 cycles, pc_sel_o=1 in the first only; branch_taken_i and ld_hazard_i together -> FLUSH wins, state_o=4.
REQ-038 imem_ready_i=0 for 5 cycles in RUN -> state_o=3 and stall_o=1 for 5 cycles, stall_cnt_o=5; halt_i pulse during the wait -> 1 RUN cycle, then state_o=5, start_o=0.
REQ-039 rst_i pulsed during MEM_WAIT -> all outputs 0 asynchronously, state_o=0; after release go_i -> RUN with stall_cnt_o=0.
REQ-040 Counter saturation with CNT_W=4: 20 stall cycles -> stall_cnt_o holds 15.
